led_blink_multi: RTL and testbench

- Multi-channel, runtime-configurable successor to the fixed 1 s single-LED blinker.
- One shared prescaler produces a tick enable at TICK_HZ. CHANNELS independent LED channels each run a mode and half-period counted in ticks.
- Channels are programmed through a simple valid/ready write port from a controller or board-level FSM.
- Sits at board top level, driving LED pins directly.

---
 rtl/led_blink_multi_pkg.sv | 21 ++
 rtl/led_blink_chan.sv | 107 ++++++++++
 rtl/led_blink_multi.sv | 94 +++++++++
 tb/tb_led_blink_multi.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/led_blink_multi_pkg.sv
// led_blink_multi_pkg: shared definitions for the multi-channel LED blinker.
//   mode_t       - channel mode encodings (OFF / ON / BLINK / ONESHOT)
//   ch_width()   - channel-select width, at least 1 bit
//   DUTY_DEFAULT - PWM duty after reset (full brightness); used only when
//                  LED_BLINK_PWM_DIM_EN is defined
package led_blink_multi_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  localparam logic [3:0] DUTY_DEFAULT = 4'd15;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_blink_chan.sv
// led_blink_chan: one LED channel. Holds mode, half-period, tick counter and
// LED state. A write always beats a tick arriving in the same cycle.
// Ports:
//   clock, reset_n       - clock, synchronous active-low reset
//   tick                 - one-cycle prescaler enable
//   wr                   - write strobe for this channel (already decoded)
//   wr_mode, wr_half     - config carried with the write
//   wr_duty, pwm_cnt     - PWM duty and shared PWM phase (LED_BLINK_PWM_DIM_EN only)
//   led                  - registered LED drive
// Optional: LED_BLINK_PWM_DIM_EN adds duty storage and PWM gating of led.
module led_blink_chan
  import led_blink_multi_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             wr,
  input  mode_t            wr_mode,
  input  logic [CNT_W-1:0] wr_half,
`ifdef LED_BLINK_PWM_DIM_EN
  input  logic [3:0]       wr_duty,
  input  logic [3:0]       pwm_cnt,
`endif
  output logic             led
);

  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             raw_q, raw_d;
  logic             at_end;

  // cnt never exceeds half-1, so this compare is the only terminal condition
  assign at_end = (cnt_q == half_q - 1'b1);

  always_comb begin
    mode_d = mode_q;
    half_d = half_q;
    cnt_d  = cnt_q;
    raw_d  = raw_q;
    if (wr) begin
      mode_d = wr_mode;
      half_d = (wr_half == '0) ? CNT_W'(1) : wr_half;
      cnt_d  = '0;
      raw_d  = (wr_mode != MODE_OFF);
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK: begin
          if (at_end) begin
            raw_d = ~raw_q;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MODE_ONESHOT: begin
          if (at_end) begin
            raw_d  = 1'b0;
            mode_d = MODE_OFF;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;  // OFF / ON hold
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mode_q <= MODE_OFF;
      half_q <= CNT_W'(1);
      cnt_q  <= '0;
      raw_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      half_q <= half_d;
      cnt_q  <= cnt_d;
      raw_q  <= raw_d;
    end
  end

`ifdef LED_BLINK_PWM_DIM_EN
  logic [3:0] duty_q, duty_d;
  logic       led_q;

  assign duty_d = wr ? wr_duty : duty_q;

  // Gate from next-state values so a write is still visible with latency 1.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      duty_q <= DUTY_DEFAULT;
      led_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      led_q  <= raw_d && (pwm_cnt <= duty_d);
    end
  end

  assign led = led_q;
`else
  assign led = raw_q;
`endif

endmodule

// File: rtl/led_blink_multi.sv
// led_blink_multi: multi-channel runtime-configurable LED blinker.
// A shared prescaler emits a one-cycle tick every CLK_HZ/TICK_HZ clocks;
// CHANNELS independent led_blink_chan instances count half-periods in ticks.
// Ports:
//   clock, reset_n   - clock, synchronous active-low reset
//   cfg_valid/ready  - write handshake (ready is 1 every cycle after reset)
//   cfg_ch           - target channel; values >= CHANNELS are accepted and dropped
//   cfg_mode         - 00 OFF, 01 ON, 10 BLINK, 11 ONESHOT
//   cfg_half         - half-period in ticks (0 is treated as 1)
//   cfg_duty         - PWM duty 0..15 (LED_BLINK_PWM_DIM_EN only)
//   led              - LED drive, active high
//   tick             - prescaler pulse, for debug / sync
// Optional: LED_BLINK_PWM_DIM_EN enables per-channel PWM dimming.
// TICK_DIV = CLK_HZ/TICK_HZ must be >= 2 and divide exactly.
module led_blink_multi
  import led_blink_multi_pkg::*;
#(
  parameter  int CLK_HZ   = 50_000_000,
  parameter  int TICK_HZ  = 1000,
  parameter  int CHANNELS = 4,
  parameter  int CNT_W    = 16,
  localparam int CH_W     = ch_width(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_half,
`ifdef LED_BLINK_PWM_DIM_EN
  input  logic [3:0]          cfg_duty,
`endif
  output logic [CHANNELS-1:0] led,
  output logic                tick
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PCNT_W   = $clog2(TICK_DIV);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);

  logic [PCNT_W-1:0] pcnt;
  logic              pwrap;

  assign pwrap = (pcnt == PCNT_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pcnt      <= '0;
      tick      <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
      tick      <= pwrap;
      pcnt      <= pwrap ? '0 : pcnt + 1'b1;
    end
  end

`ifdef LED_BLINK_PWM_DIM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + 4'd1;
  end
`endif

  logic  accept;
  mode_t wr_mode;

  assign accept  = cfg_valid && cfg_ready;
  assign wr_mode = mode_t'(cfg_mode);

  // Out-of-range cfg_ch matches no instance, so such writes vanish.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic wr;
    assign wr = accept && (cfg_ch == CH_W'(i));

    led_blink_chan #(.CNT_W(CNT_W)) u_chan (
      .clock   (clock),
      .reset_n (reset_n),
      .tick    (tick),
      .wr      (wr),
      .wr_mode (wr_mode),
      .wr_half (cfg_half),
`ifdef LED_BLINK_PWM_DIM_EN
      .wr_duty (cfg_duty),
      .pwm_cnt (pwm_cnt),
`endif
      .led     (led[i])
    );
  end

endmodule

// File: tb/tb_led_blink_multi.sv
// tb_led_blink_multi: scoreboard bench for led_blink_multi.
// The driver applies directed and random writes/resets, advances a
// tick-count reference model each edge and queues the expected outputs;
// a monitor pops one entry per edge and compares led / tick / cfg_ready.
`timescale 1ns/1ps
module tb_led_blink_multi;

  localparam int NCH   = 3;
  localparam int CNT_W = 8;
  localparam int DIV   = 10;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch = '0;
  logic [1:0]       cfg_mode = '0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic [NCH-1:0]   led;
  logic             tick;

  led_blink_multi #(
    .CLK_HZ(100), .TICK_HZ(10), .CHANNELS(NCH), .CNT_W(CNT_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_half  (cfg_half),
    .led       (led),
    .tick      (tick)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NCH-1:0] led;
    logic           tick;
    logic           ready;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  // Reference model: each channel remembers its mode, half-period and the
  // number of ticks seen since its last write; the LED follows arithmetically.
  int   m_mode[NCH];
  int   m_half[NCH];
  int   m_n[NCH];
  int   k = 0;        // edges since reset release
  bit   e_tick = 0;
  bit   e_ready = 0;

  function automatic bit model_led(input int i);
    case (m_mode[i])
      1: return 1'b1;
      2: return ((m_n[i] / m_half[i]) % 2) == 0;
      3: return m_n[i] < m_half[i];
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    bit   pre_tick  = e_tick;
    bit   pre_ready = e_ready;
    exp_t e;
    @(posedge clock);
    if (!reset_n) begin
      k = 0; e_tick = 0; e_ready = 0;
      for (int i = 0; i < NCH; i++) begin
        m_mode[i] = 0; m_half[i] = 1; m_n[i] = 0;
      end
    end else begin
      k++;
      e_ready = 1;
      e_tick  = (k % DIV) == 0;
      for (int i = 0; i < NCH; i++) begin
        if (cfg_valid && pre_ready && int'(cfg_ch) == i) begin
          m_mode[i] = int'(cfg_mode);
          m_half[i] = (cfg_half == 0) ? 1 : int'(cfg_half);
          m_n[i]    = 0;
        end else if (pre_tick) begin
          m_n[i]++;
        end
      end
    end
    for (int i = 0; i < NCH; i++) e.led[i] = model_led(i);
    e.tick  = e_tick;
    e.ready = e_ready;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic write(input int ch, input int mode, input int half);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_mode  = 2'(mode);
    cfg_half  = CNT_W'(half);
    step();
    cfg_valid = 1'b0;
  endtask

  // Monitor: one expected entry per clock edge, sampled 2 ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (led !== e.led) begin
          errors++;
          $display("FAIL led @%0t: got %b expected %b", $time, led, e.led);
        end else if (tick !== e.tick) begin
          errors++;
          $display("FAIL tick @%0t: got %b expected %b", $time, tick, e.tick);
        end else if (cfg_ready !== e.ready) begin
          errors++;
          $display("FAIL cfg_ready @%0t: got %b expected %b", $time, cfg_ready, e.ready);
        end
      end
    end
  end

  initial begin
    int guard;
    int r;
    // reset, then idle across several ticks
    reset_n = 1'b0;
    run(3);
    reset_n = 1'b1;
    run(25);

    // ch0 BLINK half=3: 30-clock half-periods
    write(0, 2, 3);
    run(70);

    // ch1 ONESHOT half=2, then idle 12+ ticks, then ON
    write(1, 3, 2);
    run(130);
    write(1, 1, 5);
    run(5);

    // ch2 BLINK half=0 written in the cycle tick is high
    guard = 0;
    while (!e_tick && guard < 2 * DIV) begin
      step();
      guard++;
    end
    write(2, 2, 0);
    run(45);

    // out-of-range channel is accepted and dropped
    write(3, 1, 7);
    run(5);

    // one-cycle reset in the middle of a ch0 half-period
    write(0, 2, 3);
    run(15);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    run(40);

    // random writes with occasional resets
    for (int c = 0; c < 700; c++) begin
      r = $urandom_range(0, 99);
      reset_n = (r >= 2);
      if (r >= 2 && r < 30) begin
        cfg_valid = 1'b1;
        cfg_ch    = 2'($urandom_range(0, 3));
        cfg_mode  = 2'($urandom_range(0, 3));
        cfg_half  = CNT_W'($urandom_range(0, 4));
      end else begin
        cfg_valid = 1'b0;
      end
      step();
    end
    reset_n   = 1'b1;
    cfg_valid = 1'b0;
    run(3);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
